keypad_entry_ctrl: RTL and testbench

- Sequences multi-digit numeric entry from the 4x4 keypad reader.
- Consumes the reader's one-cycle `flag` pulse and its `key_value`.
- Assembles up to NUM_DIGITS BCD digits, handling backspace, clear, enter and an inactivity timeout.
- Presents the finished operand to a downstream consumer through a valid/ready handshake, and exposes the live entry buffer for the 7-segment display.

---
 rtl/keypad_entry_ctrl.sv | 155 +++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - multi-digit BCD entry sequencer for the 4x4 keypad reader
module keypad_entry_ctrl #(
  parameter int          NUM_DIGITS     = 4,
  parameter int          CNT_W          = 3,
  parameter int          TIMEOUT_CYCLES = 500_000_000,
  parameter int          TIMEOUT_WIDTH  = 29,
  parameter logic [3:0]  KEY_ENTER      = 4'hF,
  parameter logic [3:0]  KEY_CLEAR      = 4'hE,
  parameter logic [3:0]  KEY_BACK       = 4'hD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_flag,
  input  logic [3:0]              key_value,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [4*NUM_DIGITS-1:0] out_bcd,
  output logic [CNT_W-1:0]        out_count,
  output logic [4*NUM_DIGITS-1:0] entry_bcd,
  output logic [CNT_W-1:0]        entry_count,
  output logic                    err_pulse,
  output logic                    timeout_pulse
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_PRESENT
  } state_t;

  state_t                   state_q, state_d;
  logic [BW-1:0]            entry_bcd_d, out_bcd_d;
  logic [CNT_W-1:0]         entry_count_d, out_count_d;
  logic                     out_valid_d, err_d, to_d;
  logic [TIMEOUT_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic                     is_digit;

  assign is_digit = (key_value <= 4'd9);

  // Next-state and next-output decode; every output comes straight from a register.
  always_comb begin
    state_d       = state_q;
    entry_bcd_d   = entry_bcd;
    entry_count_d = entry_count;
    out_bcd_d     = out_bcd;
    out_count_d   = out_count;
    out_valid_d   = out_valid;
    err_d         = 1'b0;
    to_d          = 1'b0;
    to_cnt_d      = '0;

    case (state_q)
      S_IDLE: begin
        if (key_flag) begin
          if (is_digit) begin
            entry_bcd_d   = {{(BW-4){1'b0}}, key_value};
            entry_count_d = CNT_ONE;
            state_d       = S_ENTRY;
          end else if (key_value != KEY_CLEAR) begin
            err_d = 1'b1;
          end
        end
      end

      S_ENTRY: begin
        if (key_flag) begin
          // Any key, accepted or rejected, restarts the inactivity window.
          if (is_digit) begin
            if (entry_count < CNT_MAX) begin
              entry_bcd_d   = {entry_bcd[BW-5:0], key_value};
              entry_count_d = entry_count + CNT_ONE;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_value == KEY_BACK) begin
            entry_bcd_d   = entry_bcd >> 4;
            entry_count_d = entry_count - CNT_ONE;
            if (entry_count == CNT_ONE) begin
              state_d = S_IDLE;
            end
          end else if (key_value == KEY_CLEAR) begin
            entry_bcd_d   = '0;
            entry_count_d = '0;
            state_d       = S_IDLE;
          end else if (key_value == KEY_ENTER) begin
            out_bcd_d   = entry_bcd;
            out_count_d = entry_count;
            out_valid_d = 1'b1;
            state_d     = S_PRESENT;
          end else begin
            err_d = 1'b1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          entry_bcd_d   = '0;
          entry_count_d = '0;
          to_d          = 1'b1;
          state_d       = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      S_PRESENT: begin
        // Operand is frozen until consumed; keys are refused, not queued.
        if (key_flag) begin
          err_d = 1'b1;
        end
        if (out_valid && out_ready) begin
          out_valid_d   = 1'b0;
          entry_bcd_d   = '0;
          entry_count_d = '0;
          state_d       = S_IDLE;
        end
      end

      default: begin
        state_d       = S_IDLE;
        entry_bcd_d   = '0;
        entry_count_d = '0;
        out_valid_d   = 1'b0;
      end
    endcase
  end

  // State, timeout counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      to_cnt_q      <= '0;
      entry_bcd     <= '0;
      entry_count   <= '0;
      out_bcd       <= '0;
      out_count     <= '0;
      out_valid     <= 1'b0;
      err_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      to_cnt_q      <= to_cnt_d;
      entry_bcd     <= entry_bcd_d;
      entry_count   <= entry_count_d;
      out_bcd       <= out_bcd_d;
      out_count     <= out_count_d;
      out_valid     <= out_valid_d;
      err_pulse     <= err_d;
      timeout_pulse <= to_d;
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb/tb_keypad_entry_ctrl.sv - randomized and directed checks of keypad_entry_ctrl against a digit-list model
module tb_keypad_entry_ctrl;

  localparam int ND  = 4;
  localparam int CW  = 3;
  localparam int TOC = 50;
  localparam int TOW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_flag = 1'b0;
  logic [3:0]    key_value = 4'h0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [4*ND-1:0] out_bcd;
  logic [CW-1:0] out_count;
  logic [4*ND-1:0] entry_bcd;
  logic [CW-1:0] entry_count;
  logic          err_pulse;
  logic          timeout_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  keypad_entry_ctrl #(
    .NUM_DIGITS(ND), .CNT_W(CW), .TIMEOUT_CYCLES(TOC), .TIMEOUT_WIDTH(TOW),
    .KEY_ENTER(4'hF), .KEY_CLEAR(4'hE), .KEY_BACK(4'hD)
  ) dut (
    .clk(clk), .rst(rst), .key_flag(key_flag), .key_value(key_value),
    .out_ready(out_ready), .out_valid(out_valid), .out_bcd(out_bcd),
    .out_count(out_count), .entry_bcd(entry_bcd), .entry_count(entry_count),
    .err_pulse(err_pulse), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: typed digits oldest-first, a held operand, and an idle-cycle count.
  int m_digits[$];
  bit m_presenting;
  int m_op_val, m_op_cnt;
  int m_idle;
  bit m_err, m_to;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int digits_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return v;
  endfunction

  task automatic model_step(input bit r, input bit kf, input int kv, input bit rdy);
    m_err = 0;
    m_to  = 0;
    if (r) begin
      m_digits.delete();
      m_presenting = 0;
      m_op_val = 0;
      m_op_cnt = 0;
      m_idle = 0;
    end else if (m_presenting) begin
      m_err = kf;
      if (rdy) begin
        m_presenting = 0;
        m_digits.delete();
      end
    end else if (m_digits.size() == 0) begin
      if (kf) begin
        if (kv <= 9) m_digits.push_back(kv);
        else if (kv != 14) m_err = 1;
      end
      m_idle = 0;
    end else if (kf) begin
      m_idle = 0;
      if (kv <= 9) begin
        if (m_digits.size() < ND) m_digits.push_back(kv);
        else m_err = 1;
      end else if (kv == 13) begin
        void'(m_digits.pop_back());
      end else if (kv == 14) begin
        m_digits.delete();
      end else if (kv == 15) begin
        m_op_val = digits_value();
        m_op_cnt = m_digits.size();
        m_presenting = 1;
      end else begin
        m_err = 1;
      end
    end else begin
      m_idle++;
      if (m_idle == TOC) begin
        m_digits.delete();
        m_to = 1;
        m_idle = 0;
      end
    end
  endtask

  // One clock: drive inputs, advance the model, then compare every output after the edge.
  task automatic tick(input bit r, input bit kf, input logic [3:0] kv, input bit rdy);
    rst = r;
    key_flag = kf;
    key_value = kv;
    out_ready = rdy;
    model_step(r, kf, int'(kv), rdy);
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_presenting));
    check("out_bcd", 32'(out_bcd), 32'(m_op_val));
    check("out_count", 32'(out_count), 32'(m_op_cnt));
    check("entry_bcd", 32'(entry_bcd), 32'(digits_value()));
    check("entry_count", 32'(entry_count), 32'(m_digits.size()));
    check("err_pulse", 32'(err_pulse), 32'(m_err));
    check("timeout_pulse", 32'(timeout_pulse), 32'(m_to));
    check("err_to_exclusive", 32'(err_pulse & timeout_pulse), 32'd0);
  endtask

  task automatic key(input logic [3:0] kv);
    tick(1'b0, 1'b1, kv, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    // Reset state
    tick(1'b1, 1'b0, 4'h0, 1'b0);
    tick(1'b1, 1'b0, 4'h0, 1'b0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_entry_count", 32'(entry_count), 32'd0);

    // 1,2,3 ENTER then one-cycle ready
    key(4'h1); key(4'h2); key(4'h3); key(4'hF);
    check("tp1_valid", 32'(out_valid), 32'd1);
    check("tp1_bcd", 32'(out_bcd), 32'h0123);
    check("tp1_cnt", 32'(out_count), 32'd3);
    tick(1'b0, 1'b0, 4'h0, 1'b1);
    check("tp1_consumed", 32'(out_valid), 32'd0);
    check("tp1_cleared", 32'(entry_count), 32'd0);

    // Fifth digit rejected
    key(4'h9); key(4'h8); key(4'h7); key(4'h6);
    check("tp2_full", 32'(entry_bcd), 32'h9876);
    key(4'h5);
    check("tp2_err", 32'(err_pulse), 32'd1);
    check("tp2_hold", 32'(entry_bcd), 32'h9876);
    key(4'hE);

    // Backspace behaviour and ENTER from IDLE
    key(4'h4); key(4'h5); key(4'hD); key(4'h7);
    check("tp3_bcd", 32'(entry_bcd), 32'h0047);
    check("tp3_cnt", 32'(entry_count), 32'd2);
    key(4'hD); key(4'hD);
    check("tp3_empty", 32'(entry_count), 32'd0);
    key(4'hF);
    check("tp3_enter_err", 32'(err_pulse), 32'd1);
    check("tp3_no_valid", 32'(out_valid), 32'd0);

    // Timeout after TOC idle cycles, and key in the expiry cycle wins
    key(4'h3);
    idle(TOC - 1);
    check("tp4_still_entry", 32'(entry_count), 32'd1);
    idle(1);
    check("tp4_timeout", 32'(timeout_pulse), 32'd1);
    check("tp4_cleared", 32'(entry_bcd), 32'd0);
    key(4'h3);
    idle(TOC - 1);
    key(4'h6);
    check("tp4_key_wins", 32'(timeout_pulse), 32'd0);
    check("tp4_bcd", 32'(entry_bcd), 32'h0036);
    key(4'hE);

    // PRESENT refuses keys; reset aborts
    key(4'h1); key(4'h2); key(4'hF);
    key(4'h5);
    check("tp5_err1", 32'(err_pulse), 32'd1);
    key(4'hE);
    check("tp5_err2", 32'(err_pulse), 32'd1);
    check("tp5_hold", 32'(out_bcd), 32'h0012);
    tick(1'b1, 1'b0, 4'h0, 1'b0);
    check("tp5_rst_valid", 32'(out_valid), 32'd0);
    check("tp5_rst_bcd", 32'(out_bcd), 32'd0);

    // Invalid code in IDLE and ENTRY; CLEAR in IDLE is silent
    key(4'hA);
    check("tp6_idle_err", 32'(err_pulse), 32'd1);
    key(4'h8); key(4'hA);
    check("tp6_entry_err", 32'(err_pulse), 32'd1);
    check("tp6_entry_hold", 32'(entry_bcd), 32'h0008);
    key(4'hE); key(4'hE);
    check("tp6_clear_quiet", 32'(err_pulse), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        idle($urandom_range(TOC - 2, TOC + 2));
      end else begin
        logic [3:0] kv;
        int sel;
        sel = $urandom_range(0, 9);
        kv = (sel < 6) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
        tick($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, kv,
             $urandom_range(0, 3) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
